// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared definitions for the UART transmit path: FSM state
//                encoding, default bit timing and frame-length constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Transmitter FSM states; encoding is fixed so it stays stable in debug
    // dumps and any downstream decoders.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // 27 MHz system clock / 115200 baud.
    localparam int unsigned c_DEFAULT_CLKS_PER_BIT = 234;

    // Payload width and the bit length of one 8N1 frame (start + 8 + stop).
    localparam int unsigned c_DATA_BITS      = 8;
    localparam int unsigned c_FRAME_BITS_8N1 = 1 + c_DATA_BITS + 1;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baud_tick
//  Description : Bit-period counter. Counts 0..CLKS_PER_BIT-1 and wraps;
//                wrap_o is high during the final count of each bit period.
//                clear_i forces the count back to 0 on the next edge.
//  Ports       : clk_i    - system clock
//                rst_i    - asynchronous reset, active-low
//                clear_i  - synchronous restart of the bit period
//                cnt_o    - current position inside the bit period
//                wrap_o   - last cycle of the bit period
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter  int unsigned CLKS_PER_BIT = c_DEFAULT_CLKS_PER_BIT,
    localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             wrap_o
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear_i || (cnt_q == c_CNT_MAX)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign wrap_o = (cnt_q == c_CNT_MAX);

endmodule : uart_baud_tick
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_serializer
//  Description : 8N1/8N2 UART transmitter behind the Wishbone TX slave.
//                Starts a frame on the rising edge of the level request,
//                keeps one byte pending so a back-to-back store is not lost,
//                and pulses tx_done_o in the last stop-bit cycle.
//  Ports       : clk_i           - system clock
//                rst_i           - asynchronous reset, active-low
//                tx_data_i       - byte to send, sampled on acceptance
//                tx_data_valid_i - level request; rising edge = new byte
//                tx_o            - serial line, idle high (registered)
//                tx_busy_o       - frame in flight or byte pending
//                tx_done_o       - one-cycle pulse, last stop-bit cycle
//                overrun_o       - one-cycle pulse when a byte is dropped
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = c_DEFAULT_CLKS_PER_BIT,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_data_valid_i,
    output logic       tx_o,
    output logic       tx_busy_o,
    output logic       tx_done_o,
    output logic       overrun_o
);

    localparam int unsigned      CNT_W          = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    // Count value one cycle before the wrap; lets tx_done_o be registered
    // yet line up exactly with the final stop-bit cycle.
    localparam logic [CNT_W-1:0] c_CNT_PRE_WRAP = CNT_W'(CLKS_PER_BIT - 2);

    uart_state_e state_q,     state_d;
    logic [7:0]  shift_q,     shift_d;
    logic [2:0]  bit_idx_q,   bit_idx_d;
    logic        stop_idx_q,  stop_idx_d;
    logic        pend_full_q, pend_full_d;
    logic [7:0]  pend_data_q, pend_data_d;
    logic        tx_q,        tx_d;
    logic        busy_q,      busy_d;
    logic        done_q,      done_d;
    logic        overrun_q,   overrun_d;
    logic        valid_d_q;

    logic             w_req;
    logic             w_last_stop;
    logic             w_end_frame;
    logic             w_drain;
    logic             w_baud_clear;
    logic             w_baud_wrap;
    logic [CNT_W-1:0] w_baud_cnt;

    assign w_req       = tx_data_valid_i & ~valid_d_q;
    assign w_last_stop = (STOP_BITS == 1) ? 1'b1 : stop_idx_q;
    assign w_end_frame = (state_q == ST_STOP) & w_baud_wrap & w_last_stop;
    // The pending slot empties this cycle when its byte is moved into the
    // shift register, so a coincident request can take the slot.
    assign w_drain     = pend_full_q & ((state_q == ST_IDLE) | w_end_frame);
    // Every state entry restarts the bit period; idle keeps it parked at 0.
    assign w_baud_clear = (state_q == ST_IDLE) | (state_d != state_q);

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (w_baud_clear),
        .cnt_o   (w_baud_cnt),
        .wrap_o  (w_baud_wrap)
    );

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_idx_d   = bit_idx_q;
        stop_idx_d  = stop_idx_q;
        pend_full_d = pend_full_q;
        pend_data_d = pend_data_q;
        tx_d        = tx_q;
        done_d      = 1'b0;
        overrun_d   = 1'b0;

        // Frame sequencing
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                // Only reachable when a request landed on the tx_done cycle.
                if (pend_full_q) begin
                    shift_d     = pend_data_q;
                    pend_full_d = 1'b0;
                    state_d     = ST_START;
                    tx_d        = 1'b0;
                end
            end
            ST_START: begin
                if (w_baud_wrap) begin
                    state_d   = ST_DATA;
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                end
            end
            ST_DATA: begin
                if (w_baud_wrap) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d    = ST_STOP;
                        stop_idx_d = 1'b0;
                        tx_d       = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end
            end
            ST_STOP: begin
                if (w_last_stop && (w_baud_cnt == c_CNT_PRE_WRAP)) begin
                    done_d = 1'b1;
                end
                if (w_baud_wrap) begin
                    if (w_last_stop) begin
                        if (pend_full_q) begin
                            // Chain straight into the next start bit.
                            shift_d     = pend_data_q;
                            pend_full_d = 1'b0;
                            state_d     = ST_START;
                            tx_d        = 1'b0;
                        end else begin
                            state_d = ST_IDLE;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Request acceptance
        if (w_req) begin
            if ((state_q == ST_IDLE) && !pend_full_q) begin
                shift_d = tx_data_i;
                state_d = ST_START;
                tx_d    = 1'b0;
            end else if (!pend_full_q || w_drain) begin
                pend_full_d = 1'b1;
                pend_data_d = tx_data_i;
            end else begin
                overrun_d = 1'b1;
            end
        end

        busy_d = (state_d != ST_IDLE) | pend_full_d;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_IDLE;
            shift_q     <= 8'h00;
            bit_idx_q   <= 3'd0;
            stop_idx_q  <= 1'b0;
            pend_full_q <= 1'b0;
            pend_data_q <= 8'h00;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
            // A level already high at reset release must not look like an edge.
            valid_d_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_idx_q   <= bit_idx_d;
            stop_idx_q  <= stop_idx_d;
            pend_full_q <= pend_full_d;
            pend_data_q <= pend_data_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
            valid_d_q   <= tx_data_valid_i;
        end
    end

    assign tx_o      = tx_q;
    assign tx_busy_o = busy_q;
    assign tx_done_o = done_q;
    assign overrun_o = overrun_q;

endmodule : uart_tx_serializer
`default_nettype wire

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Downstream stage of the Wishbone UART TX slave.
- Consumes the 8-bit byte and the level-type "tx data valid" that the slave holds high for the whole Wishbone cycle.
- Serialises the byte as 8N1 (or 8N2) on the physical TX pin.
- Returns a one-cycle completion pulse that feeds the slave's transmission_done input. Includes a one-entry pending buffer so a back-to-back store is not lost.

Parameters:
- CLKS_PER_BIT, 234, clock cycles per UART bit (27 MHz / 115200); must be >= 2.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  asynchronous reset, active-low
- tx_data_i  input  8  byte to send; sampled on the acceptance cycle
- tx_data_valid_i  input  1  level request from the Wishbone slave; only its rising edge starts a transfer
- tx_o  output  1  serial line; idle high
- tx_busy_o  output  1  high while a frame is in flight or a byte is pending
- tx_done_o  output  1  one-cycle pulse at the end of the final stop bit of each frame
- overrun_o  output  1  one-cycle pulse when a request is dropped

Behaviour:
- Reset (rst_i low, asynchronous) forces:
  - tx_o=1, tx_busy_o=0, tx_done_o=0, overrun_o=0
  - state=IDLE, pending empty, counters 0
  - valid_d=1, so a valid level already high at reset release is not treated as an edge.
- Edge detect: valid_d registers tx_data_valid_i every cycle; request = tx_data_valid_i & ~valid_d.
- Acceptance:
  - Request in IDLE with pending empty: latch tx_data_i into the shift register and enter START on the next edge.
  - Request while not IDLE and pending empty: latch into pending.
  - Request while pending full: drop the byte, pulse overrun_o.
- FSM states: IDLE, START, DATA, STOP, all registered.
  - START: tx_o=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles; 3-bit bit index counts 0..7.
  - STOP: tx_o=1 for STOP_BITS*CLKS_PER_BIT cycles.
- Latency: tx_o falls on the first clock edge after the acceptance cycle. The frame lasts (1+8+STOP_BITS)*CLKS_PER_BIT cycles.
- Baud counter:
  - Width $clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1, then wraps to 0 and advances the bit or state.
  - Reset to 0 on every state entry.
- End of last stop-bit cycle:
  - tx_done_o=1 for exactly that cycle.
  - If pending is full: move pending to the shift register, clear pending, go directly to START; no idle high gap beyond the stop bits.
  - Otherwise: go to IDLE.
- Simultaneous events:
  - Request on the same cycle pending drains: the request is stored into pending, not dropped.
  - Request on the same cycle as tx_done_o with pending empty: the request goes to pending and is started next.
- tx_busy_o = (state != IDLE) | pending_full. It is registered and remains high through the tx_done_o cycle when a pending byte follows.
- tx_o is a registered output; no combinational path from inputs to tx_o.
- Reset mid-frame: tx_o returns high immediately (asynchronous); the partial frame is abandoned and the pending byte discarded.
- Data is sampled only on acceptance; later changes of tx_data_i have no effect on the frame in flight.

Decomposition:
- Shared package uart_pkg:
  - state encoding localparams (IDLE=0, START=1, DATA=2, STOP=3)
  - default CLKS_PER_BIT
  - 8N1 frame-length constant
- One natural sub-module: uart_baud_tick, a parameterised counter with a clear input and a wrap pulse output.
- Edge detect, pending buffer and FSM stay in the top module.

Test Plan:
- CLKS_PER_BIT=4; single byte 0xA5, valid held high 10 cycles:
  - tx_o sequence, 4 cycles each: 0, 1,0,1,0,0,1,0,1, 1.
  - tx_done_o pulses once, 40 cycles after the first start-bit cycle.
  - No second frame despite the held level.
- Back-to-back 0x55 then 0x0F, second rising edge during DATA of the first:
  - second frame starts the cycle after the first tx_done_o; no extra idle bit.
  - two tx_done_o pulses; tx_busy_o is continuous.
- Three edges (0x01, 0x02, 0x03) during the first frame: 0x01 and 0x02 are sent; 0x03 is dropped with one overrun_o pulse.
- rst_i low at bit 3 of 0xFF:
  - tx_o=1 and tx_busy_o=0 immediately.
  - after release, a fresh edge with 0x3C sends a clean frame.
- tx_data_valid_i high across reset release: no frame. Drop valid, raise it again: one frame sent.
- STOP_BITS=2, CLKS_PER_BIT=4, byte 0x80: stop high lasts 8 cycles; tx_done_o at frame cycle 44.
